// File: rtl/memory_reader_if.sv
// Bus bundle between the read sequencer, the byte memory and the downstream consumer.
// The master side is the sequencer. It drives the memory address and read enable, and it
// drives the output byte and its valid flag. The slave side is the memory and consumer
// pair seen from the outside.
interface memory_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  mem_data,
    input  out_ready,
    output mem_addr,
    output mem_rd_en,
    output out_data,
    output out_addr,
    output out_valid
  );

  modport slave (
    output mem_data,
    output out_ready,
    input  mem_addr,
    input  mem_rd_en,
    input  out_data,
    input  out_addr,
    input  out_valid
  );
endinterface

// File: rtl/memory_reader.sv
// Read-side sequencer for the small byte memory.
// A start pulse walks every address from 0 upward. For each address the sequencer holds
// the address and read enable long enough for the read mux to settle, captures the byte,
// and offers it downstream on a valid/ready handshake. A one-cycle done pulse follows
// acceptance of the last byte.
module memory_reader #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  memory_reader_if.master bus,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT
  } state_t;

  // The capture edge is the one where the settle counter reaches this value.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t     state;
  logic [3:0] settle_cnt;

  // Scan sequencer: every output is registered, and reset abandons any scan in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= SETTLE;
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b1;
            settle_cnt    <= '0;
            busy          <= 1'b1;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            bus.out_data  <= bus.mem_data;
            bus.out_addr  <= bus.mem_addr;
            bus.out_valid <= 1'b1;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.mem_addr == ADDR_MAX) begin
              bus.mem_rd_en <= 1'b0;
              bus.mem_addr  <= '0;
              done          <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              bus.mem_addr <= bus.mem_addr + 1'b1;
              settle_cnt   <= '0;
              state        <= SETTLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
